// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter that hands one small AND/OR/XOR/ADD datapath to NREQ
// requesters in turn. Each winner's operands are captured, evaluated one
// cycle later and returned through a valid/ready result port with the
// winner's index attached.
//
// Result handshake: out_valid rises when a result is ready and then holds,
// with out_ans/out_id frozen, until a rising clock edge where out_valid and
// out_ready are both high. That edge is the transfer. out_ready may already
// be high in the first cycle of out_valid. out_valid never depends
// combinationally on out_ready.
module alu_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] in_a,
  input  logic [NREQ*WIDTH-1:0] in_b,
  input  logic [NREQ*2-1:0]     op,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_ans,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [1:0]        op_q;

  logic              hi_found;
  logic              lo_found;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   rr_next;
  logic [NREQ-1:0]   win_onehot;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  alu_res;

  // Round-robin pick: lowest requester at or above rr_ptr, otherwise the
  // lowest requester overall (the scan wraps past NREQ-1 back to 0).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    win        = hi_found ? hi_idx : lo_idx;
    rr_next    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
  end

  // Operand mux selecting the winner's packed slice.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win) begin
        sel_a  = in_a[i*WIDTH +: WIDTH];
        sel_b  = in_b[i*WIDTH +: WIDTH];
        sel_op = op[i*2 +: 2];
      end
    end
  end

  // Shared ALU on the latched operands; ADD drops the carry out.
  always_comb begin
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_ADD:  alu_res = a_q + b_q;
      default: alu_res = '0;
    endcase
  end

  // Control FSM: grant and latch in IDLE, evaluate in EXEC, hold the result
  // in RESP until it is taken. req is only looked at in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_ans   <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= '0;
          if (lo_found) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            id_q   <= win;
            gnt    <= win_onehot;
            rr_ptr <= rr_next;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt       <= '0;
          out_ans   <= alu_res;
          out_id    <= id_q;
          out_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          gnt <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// with expected results queued at issue time and checked by a monitor.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [7:0]  op;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ans;
  logic [1:0]  out_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // model state
  int         rr_m = 0;
  logic [5:0] exp_q[$];
  int         cyc = 0;
  int         last_gnt_cyc = -1;

  // ready-driver controls
  bit rand_ready = 1'b0;
  int stall_len  = 0;
  int stall_tok  = 0;

  alu_share_arbiter #(.NREQ(4), .WIDTH(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_a      (in_a),
    .in_b      (in_b),
    .op        (op),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ans   (out_ans),
    .out_id    (out_id),
    .busy      (busy)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic int alu_ref(input int x, input int y, input int o);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      default: return (x + y) % 16;
    endcase
  endfunction

  // out_ready driver: held low for a requested stretch, else random or high
  initial begin
    int seen_tok;
    int left;
    seen_tok  = 0;
    left      = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_tok != seen_tok) begin
        seen_tok = stall_tok;
        left     = stall_len;
      end
      if (left > 0) begin
        out_ready = 1'b0;
        left      = left - 1;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // monitor: pops the scoreboard on every accepted result, checks hold rules
  initial begin
    bit         stall_prev;
    bit         hs_prev;
    logic [3:0] prev_ans;
    logic [1:0] prev_id;
    logic [5:0] e;
    stall_prev = 1'b0;
    hs_prev    = 1'b0;
    prev_ans   = '0;
    prev_id    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        hs_prev    = 1'b0;
      end else begin
        if (hs_prev) check("valid_drop_after_accept", 32'(out_valid), 32'd0);
        hs_prev = 1'b0;
        if (out_valid) begin
          if (stall_prev) begin
            check("stall_ans_stable", 32'(out_ans), 32'(prev_ans));
            check("stall_id_stable", 32'(out_id), 32'(prev_id));
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("out_ans", 32'(out_ans), 32'(e[3:0]));
              check("out_id", 32'(out_id), 32'(e[5:4]));
            end
            hs_prev    = 1'b1;
            stall_prev = 1'b0;
          end else begin
            check("stall_gnt_zero", 32'(gnt), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            stall_prev = 1'b1;
            prev_ans   = out_ans;
            prev_id    = out_id;
          end
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  // assert reset now, clear the model, release on a falling edge
  task automatic apply_reset(input int cycles, input bit chk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    if (chk) begin
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ans", 32'(out_ans), 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    exp_q.delete();
    rr_m         = 0;
    last_gnt_cyc = -1;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive one request pattern, predict the winner and its result, check grant
  task automatic issue(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] o, input logic [3:0] dir_gnt,
                       input bit chk_gap, input int stall);
    int  w;
    int  idx;
    int  ans;
    bit  got;
    @(posedge clk);
    #1;
    req  = r;
    in_a = a;
    in_b = b;
    op   = o;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (rr_m + k) % 4;
      if (w < 0 && ((int'(r) >> idx) & 1) == 1) w = idx;
    end
    ans = alu_ref((int'(a) >> (4 * w)) & 15, (int'(b) >> (4 * w)) & 15,
                  (int'(o) >> (2 * w)) & 3);
    exp_q.push_back({2'(w), 4'(ans)});
    rr_m = (w + 1) % 4;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) got = 1'b1;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (got) begin
      check("gnt_winner", 32'(gnt), 32'(1 << w));
      if (dir_gnt != 4'd0) check("gnt_directed", 32'(gnt), 32'(dir_gnt));
      check("busy_at_gnt", 32'(busy), 32'd1);
      if (chk_gap && last_gnt_cyc >= 0) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd3);
      last_gnt_cyc = cyc;
      if (stall > 0) begin
        stall_len = stall;
        stall_tok = stall_tok + 1;
      end
      @(negedge clk);
      check("valid_rise", 32'(out_valid), 32'd1);
      check("gnt_pulse_end", 32'(gnt), 32'd0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // stimulus
  initial begin
    logic [3:0] dir_seq[6];
    bit got;
    dir_seq[0] = 4'b0001; dir_seq[1] = 4'b0010; dir_seq[2] = 4'b0100;
    dir_seq[3] = 4'b1000; dir_seq[4] = 4'b0001; dir_seq[5] = 4'b0010;
    req  = '0;
    in_a = '0;
    in_b = '0;
    op   = '0;
    @(negedge clk);
    apply_reset(3, 1'b1);

    // basic AND from requester 0
    issue(4'b0001, 16'h0005, 16'h0003, 8'h00, 4'b0001, 1'b0, 0);
    // requester 2: ADD wrap, OR, XOR
    issue(4'b0100, 16'h0F00, 16'h0200, 8'b00110000, 4'b0100, 1'b0, 0);
    issue(4'b0100, 16'h0F00, 16'h0200, 8'b00010000, 4'b0100, 1'b0, 0);
    issue(4'b0100, 16'h0F00, 16'h0200, 8'b00100000, 4'b0100, 1'b0, 0);
    drain();

    // all requesting from reset: strict rotation, one grant every 3 cycles
    @(negedge clk);
    apply_reset(2, 1'b0);
    for (int i = 0; i < 6; i++)
      issue(4'b1111, 16'($urandom), 16'($urandom), 8'($urandom), dir_seq[i], 1'b1, 0);

    // consumer stalls while everyone keeps requesting
    issue(4'b1111, 16'h4321, 16'h1234, 8'hE4, 4'b0100, 1'b0, 6);
    drain();

    // reset during EXEC discards the in-flight result
    @(posedge clk);
    #1;
    req  = 4'b0001;
    in_a = 16'h0009;
    in_b = 16'h0006;
    op   = 8'h03;
    got  = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) got = 1'b1;
    end
    check("exec_rst_gnt", 32'(gnt), 32'b0001);
    apply_reset(2, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("no_valid_after_rst", 32'(out_valid), 32'd0);
    end
    issue(4'b1010, 16'($urandom), 16'($urandom), 8'($urandom), 4'b0010, 1'b0, 0);

    // pointer wrap: after granting 2, {0,2} requesting goes to 0
    issue(4'b0100, 16'($urandom), 16'($urandom), 8'($urandom), 4'b0100, 1'b0, 0);
    issue(4'b0101, 16'($urandom), 16'($urandom), 8'($urandom), 4'b0001, 1'b0, 0);
    drain();

    // random traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
          req = '0;
        end
      end
      issue(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), 8'($urandom),
            4'b0000, 1'b0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0);
    end
    @(posedge clk);
    #1;
    req = '0;
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
